// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the ram_arbiter scratchpad arbiter.
// cmd_t describes one granted command at the default widths; clog2 sizes the id fields.
package ram_arb_pkg;

    localparam int RAM_ARB_N  = 4;
    localparam int RAM_ARB_AW = 16;
    localparam int RAM_ARB_DW = 16;

    // Ceiling log2 for values >= 2; used to size requester ids.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int RAM_ARB_IDW = clog2(RAM_ARB_N);

    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic [RAM_ARB_IDW-1:0] id;
        logic [RAM_ARB_AW-1:0]  addr;
        logic [RAM_ARB_DW-1:0]  wdata;
    } cmd_t;

endpackage

// File: rtl/ram_arbiter_rr_picker.sv
// Round-robin picker: rotate requests so rr_ptr sits at bit 0, take the lowest
// set bit, then rotate the winner back to an absolute requester id.
module rr_picker #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_ptr,
    output logic [N-1:0]   o_grant,
    output logic [IDW-1:0] o_id,
    output logic           o_any
);

    localparam logic [N-1:0]   ONE_N = {{(N-1){1'b0}}, 1'b1};
    localparam logic [IDW:0]   N_EXT = (IDW+1)'(N);

    logic [N-1:0]   w_rot;
    logic [IDW-1:0] w_off;
    logic [IDW:0]   w_sum;

    assign w_rot = N'({i_req, i_req} >> i_ptr);

    // Lowest set bit of the rotated vector is the winner's offset from rr_ptr.
    always_comb begin
        w_off = '0;
        o_any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IDW'(k);
                o_any = 1'b1;
            end
        end
    end

    assign w_sum   = {1'b0, i_ptr} + {1'b0, w_off};
    assign o_id    = (w_sum >= N_EXT) ? IDW'(w_sum - N_EXT) : IDW'(w_sum);
    assign o_grant = o_any ? (ONE_N << o_id) : '0;

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin sharing of one async-read/sync-write scratchpad among
// N requesters. Stage A grants one command per cycle into cmd_q; stage B drives
// the RAM from cmd_q and registers read data with the requester id.
// Optional feature: define RAM_ARB_LOCK_EN to add req_lock, letting a requester
// hold exclusive access across consecutive grants.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int N  = RAM_ARB_N,
    parameter int AW = RAM_ARB_AW,
    parameter int DW = RAM_ARB_DW
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N-1:0]          req_valid,
    output logic [N-1:0]          req_ready,
    input  logic [N-1:0]          req_we,
    input  logic [N*AW-1:0]       req_addr,
    input  logic [N*DW-1:0]       req_wdata,
`ifdef RAM_ARB_LOCK_EN
    input  logic [N-1:0]          req_lock,
`endif
    output logic                  resp_valid,
    output logic [clog2(N)-1:0]   resp_id,
    output logic [DW-1:0]         resp_data,
    output logic [AW-1:0]         ram_raddr,
    output logic [AW-1:0]         ram_waddr,
    output logic [DW-1:0]         ram_din,
    output logic                  ram_we,
    input  logic [DW-1:0]         ram_dout
);

    localparam int IDW = clog2(N);
    localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

    // Same layout as ram_arb_pkg::cmd_t, sized by this instance's parameters.
    typedef struct packed {
        logic           valid;
        logic           we;
        logic [IDW-1:0] id;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  wdata;
    } cmd_q_t;

    logic [N-1:0]   w_req;
    logic [N-1:0]   w_grant;
    logic [IDW-1:0] w_gid;
    logic           w_any;
    logic           w_hs;

    logic [IDW-1:0] r_rr_ptr;
    cmd_q_t         r_cmd_q;

`ifdef RAM_ARB_LOCK_EN
    logic           r_lock_q;
    logic [IDW-1:0] r_lock_id;
    logic           w_lock_hold;

    // Lock stays effective only while its owner keeps req_lock raised.
    assign w_lock_hold = r_lock_q & req_lock[r_lock_id];

    // While locked, everyone but the owner is masked out of the search.
    always_comb begin
        w_req = req_valid;
        if (w_lock_hold) begin
            w_req = req_valid & (ONE_N << r_lock_id);
        end
    end

    // Lock is taken on a locked handshake and released when the owner drops req_lock.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_lock_q  <= 1'b0;
            r_lock_id <= '0;
        end else if (w_hs && req_lock[w_gid]) begin
            r_lock_q  <= 1'b1;
            r_lock_id <= w_gid;
        end else if (r_lock_q && !req_lock[r_lock_id]) begin
            r_lock_q  <= 1'b0;
        end
    end
`else
    assign w_req = req_valid;
`endif

    rr_picker #(
        .N   (N),
        .IDW (IDW)
    ) u_picker (
        .i_req   (w_req),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_id    (w_gid),
        .o_any   (w_any)
    );

    // Stage B drains every cycle, so any pick is accepted unless in reset.
    assign req_ready = w_grant & {N{~reset}};
    assign w_hs      = w_any & ~reset;

    // Stage A: capture the granted command and advance the round-robin pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr_ptr <= '0;
            r_cmd_q  <= '0;
        end else begin
            r_cmd_q.valid <= w_hs;
            if (w_hs) begin
                r_cmd_q.we    <= req_we[w_gid];
                r_cmd_q.id    <= w_gid;
                r_cmd_q.addr  <= req_addr[w_gid*AW +: AW];
                r_cmd_q.wdata <= req_wdata[w_gid*DW +: DW];
                r_rr_ptr      <= (w_gid == IDW'(N - 1)) ? '0 : w_gid + IDW'(1);
            end
        end
    end

    assign ram_raddr = r_cmd_q.addr;
    assign ram_waddr = r_cmd_q.addr;
    assign ram_din   = r_cmd_q.wdata;
    assign ram_we    = r_cmd_q.valid & r_cmd_q.we & ~reset;

    // Stage B: register async read data with its requester id; writes are silent.
    always_ff @(posedge clock) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
        end else if (r_cmd_q.valid && !r_cmd_q.we) begin
            resp_valid <= 1'b1;
            resp_id    <= r_cmd_q.id;
            resp_data  <= ram_dout;
        end else begin
            resp_valid <= 1'b0;
        end
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single `ram_sim` scratchpad (async read, sync write) among `N` requesters, such as the filter, ifmap and psum loaders of the PE array. The block arbitrates round-robin with one access per cycle and registers the granted command. It drives the RAM ports from that register and returns read data through a registered response bus tagged with the requester id. It sits directly between the loader/writeback engines and the `ram_sim` instance.

## Interface
- `N`, 4: number of requesters (2..8).
- `AW`, 16: address width; must match `ram_sim` `aw`.
- `DW`, 16: data width; must match `ram_sim` `dw`.
- `IDW`, derived as clog2(N): id width. Local, not overridable.

Ports:
- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  N: bit i means requester i has a command.
- `req_ready`  out  N: bit i is the grant to requester i. The handshake completes when valid and ready are both high.
- `req_we`  in  N: bit i set is a write, clear is a read.
- `req_addr`  in  N*AW: flattened; requester i occupies bits [i*AW +: AW].
- `req_wdata`  in  N*DW: flattened; requester i occupies bits [i*DW +: DW].
- `resp_valid`  out  1: read data valid. One cycle per read; there is no backpressure.
- `resp_id`  out  IDW: requester that issued the read.
- `resp_data`  out  DW: read data.
- `ram_raddr`  out  AW: to `ram_sim.raddr`.
- `ram_waddr`  out  AW: to `ram_sim.waddr`.
- `ram_din`  out  DW: to `ram_sim.din`.
- `ram_we`  out  1: to `ram_sim.we`.
- `ram_dout`  in  DW: from `ram_sim.dout`.
- `req_lock`  in  N: present only with `RAM_ARB_LOCK_EN` (see Configuration).

## Operation
- Stage A (grant):
  - Pick the first requester with `req_valid` high, searching from `rr_ptr` upward with wrap-around modulo N.
  - Raise exactly that requester's `req_ready` bit, combinationally.
  - At most one ready bit is high per cycle.
  - Stage A always accepts, because stage B drains every cycle.
- On a handshake, register {valid, we, id, addr, wdata} into `cmd_q` and set `rr_ptr` to (granted id + 1) mod N.
  - If there is no handshake, `cmd_q.valid` is cleared and `rr_ptr` holds.
- Stage B (access):
  - `ram_raddr` and `ram_waddr` both take `cmd_q.addr`; `ram_din` takes `cmd_q.wdata`.
  - `ram_we` is `cmd_q.valid & cmd_q.we & ~reset`.
  - For a read, `ram_dout` is captured into `resp_data` at the end of the cycle, with `resp_valid` set to 1 and `resp_id` set to `cmd_q.id`.
  - In any other case `resp_valid` is 0 and `resp_data`/`resp_id` hold.
- Writes produce no response; the `req_ready` handshake is their acknowledgement.
- Ordering:
  - Commands execute strictly in grant order.
  - A read granted in the cycle after a write to the same address returns the new data. The write commits at the stage-B edge; the read samples in the following stage B.
- Reset:
  - `req_ready` is forced to 0 and `ram_we` to 0 while `reset` is high.
  - Any in-flight `cmd_q` is discarded; a write held in it is not performed.
  - A read held in it produces no response.
- Reset values: `rr_ptr`=0, `cmd_q.valid`=0, `resp_valid`=0, `resp_id`=0, `resp_data`=0.
  - The RAM address and data outputs are 0, because they follow the cleared `cmd_q`.

## Timing
- Handshake in cycle t puts the RAM access in cycle t+1.
- A read response appears in cycle t+2 (`resp_valid`, `resp_id`, `resp_data`), registered.
- A write commits to memory at the clock edge that ends cycle t+1.
- Throughput is one command per cycle in aggregate.
  - With all N requesters continuously valid, each is granted once every N cycles.
- `req_ready` depends combinationally on `req_valid` (and on `req_lock`). Requesters must not make `req_valid` depend on `req_ready`.

## Configuration
- `RAM_ARB_LOCK_EN` defined:
  - Adds the `req_lock` input and a `lock_q`/`lock_id` register, both reset to 0.
  - A handshake by requester i with `req_lock[i]`=1 sets `lock_q`=1 and `lock_id`=i.
  - While `lock_q`=1, only `lock_id` may receive ready; all other requesters wait.
  - `lock_q` clears in any cycle where `req_lock[lock_id]`=0. The grant search that cycle then proceeds normally from `rr_ptr`.
  - `rr_ptr` still advances on each locked grant.
- Macro undefined: no `req_lock` port and no lock logic; pure round-robin.

## Structure
- Package `ram_arb_pkg`:
  - `cmd_t` struct {valid, we, id, addr, wdata}, parameterized via localparams.
  - A clog2 helper function.
  - Default constants `RAM_ARB_N`, `RAM_ARB_AW`, `RAM_ARB_DW`.
- Sub-module `rr_picker`:
  - Combinational rotate/priority-encode/rotate-back.
  - Inputs: request vector and `rr_ptr`.
  - Outputs: one-hot grant, grant id, any-grant.
  - Instantiated once. The lock masking is applied to its request vector in the top.

## Test plan
- Single read:
  - Stimulus: RAM preloaded with mem[0x0010]=0xBEEF; requester 2 reads 0x0010 at cycle 5.
  - Response: `req_ready[2]`=1 in cycle 5; `resp_valid`=1, `resp_id`=2, `resp_data`=0xBEEF in cycle 7.
- Write then read:
  - Stimulus: requester 0 writes 0x1234 to 0x0003 in cycle t; requester 0 reads 0x0003 in cycle t+1.
  - Response: `ram_we`=1 in t+1; `resp_data`=0x1234 with `resp_id`=0 in t+3.
- Fairness:
  - Stimulus: all 4 requesters hold `req_valid`=1 for 8 cycles from reset.
  - Response: grant order is 0,1,2,3,0,1,2,3; exactly one ready bit is high per cycle.
- Reset mid-operation:
  - Stimulus: requester 1 is granted a write in cycle t, and `reset`=1 during t+1.
  - Response: `ram_we`=0 in t+1; memory is unchanged; `resp_valid`=0; `rr_ptr`=0 after reset.
- Lock (`RAM_ARB_LOCK_EN`):
  - Stimulus: requester 3 reads with `req_lock`=1 for 3 cycles while requesters 0 and 1 are valid.
  - Response: only `req_ready[3]` is high for those 3 cycles. After `req_lock[3]` drops, requester 0 is granted next.
- Idle:
  - Stimulus: `req_valid`=0 for 10 cycles.
  - Response: `req_ready`=0, `ram_we`=0, `resp_valid`=0, `rr_ptr` unchanged.
